// File: rtl/traffic_light_monitor.sv
// Passive monitor for a two-approach signal-head bus: decodes phase, checks encoding, order and dwell.
// Optional macro TLM_TIMING_CHECK_EN enables the dwell-time checks (short/long error codes).
module traffic_light_monitor #(
  parameter int T_AG  = 4,
  parameter int T_AY  = 1,
  parameter int T_BG  = 3,
  parameter int T_BY  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [2:0]       a_i,
  input  logic [2:0]       b_i,
  output logic [1:0]       phase_o,
  output logic             locked_o,
  output logic [7:0]       dwell_o,
  output logic             err_o,
  output logic [2:0]       err_code_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] cycles_done_o
);

`ifdef TLM_TIMING_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  typedef enum logic       {SYNC, TRACK} state_e;
  typedef enum logic [1:0] {PH_AG = 2'd0, PH_AY = 2'd1, PH_BG = 2'd2, PH_BY = 2'd3} phase_e;

  localparam logic [2:0] E_ENC   = 3'd1;
  localparam logic [2:0] E_ORDER = 3'd2;
  localparam logic [2:0] E_SHORT = 3'd3;
  localparam logic [2:0] E_LONG  = 3'd4;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             timed_q, timed_d;   // current phase entered via a legal successor
  logic             long_q, long_d;     // long error already reported for this occurrence
  logic             loop_q, loop_d;     // an unbroken loop started at a timed AG entry
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic       legal;
  phase_e     smp;
  logic [2:0] hit;

  function automatic logic [7:0] tx_f(input phase_e p);
    case (p)
      PH_AG:   tx_f = 8'(T_AG);
      PH_AY:   tx_f = 8'(T_AY);
      PH_BG:   tx_f = 8'(T_BG);
      default: tx_f = 8'(T_BY);
    endcase
  endfunction

  always_comb begin
    legal = 1'b1;
    smp   = PH_AG;
    case ({a_i, b_i})
      6'b001_100: smp = PH_AG;
      6'b010_100: smp = PH_AY;
      6'b100_001: smp = PH_BG;
      6'b100_010: smp = PH_BY;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    timed_d = timed_q;
    long_d  = long_q;
    loop_d  = loop_q;
    err_d   = err_q;
    code_d  = code_q;
    pulse_d = 1'b0;
    cyc_d   = cyc_q;
    hit     = 3'd0;

    if (!legal) begin
      hit     = E_ENC;
      state_d = SYNC;
      dwell_d = 8'd0;
      timed_d = 1'b0;
      long_d  = 1'b0;
      loop_d  = 1'b0;
    end else if (state_q == SYNC) begin
      state_d = TRACK;
      phase_d = smp;
      dwell_d = 8'd1;
      timed_d = 1'b0;
      long_d  = 1'b0;
      loop_d  = 1'b0;
    end else if (smp == phase_q) begin
      dwell_d = (dwell_q == 8'hFF) ? 8'hFF : dwell_q + 8'd1;
      if (TCHK && timed_q && !long_q && (dwell_q >= tx_f(phase_q))) begin
        hit    = E_LONG;
        long_d = 1'b1;
      end
    end else if (smp == phase_e'(phase_q + 2'd1)) begin
      phase_d = smp;
      dwell_d = 8'd1;
      timed_d = 1'b1;
      long_d  = 1'b0;
      if (TCHK && timed_q && (dwell_q < tx_f(phase_q)))
        hit = E_SHORT;
      if (smp == PH_AG) begin
        if (loop_q)
          cyc_d = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
        loop_d = 1'b1;
      end
    end else begin
      hit     = E_ORDER;
      phase_d = smp;
      dwell_d = 8'd1;
      timed_d = 1'b0;
      long_d  = 1'b0;
      loop_d  = 1'b0;
    end

    if (hit != 3'd0) begin
      pulse_d = 1'b1;
      err_d   = 1'b1;
      if (!err_q)
        code_d = hit;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= SYNC;
      phase_q <= PH_AG;
      dwell_q <= 8'd0;
      timed_q <= 1'b0;
      long_q  <= 1'b0;
      loop_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      pulse_q <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      timed_q <= timed_d;
      long_q  <= long_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
      cyc_q   <= cyc_d;
    end
  end

  assign phase_o       = phase_q;
  assign locked_o      = (state_q == TRACK);
  assign dwell_o       = dwell_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;
  assign err_pulse_o   = pulse_q;
  assign cycles_done_o = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; expectations follow TLM_TIMING_CHECK_EN.
module tb_traffic_light_monitor;

`ifdef TLM_TIMING_CHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  a = R, b = R;
  logic [1:0]  phase;
  logic        locked, err, err_pulse;
  logic [7:0]  dwell;
  logic [2:0]  err_code;
  logic [15:0] cycles_done;

  int passed = 0;
  int total  = 0;

  traffic_light_monitor dut (
    .clk_i(clk), .reset_i(reset), .a_i(a), .b_i(b),
    .phase_o(phase), .locked_o(locked), .dwell_o(dwell), .err_o(err),
    .err_code_o(err_code), .err_pulse_o(err_pulse), .cycles_done_o(cycles_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic [2:0] av, input logic [2:0] bv);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input logic [2:0] av, input logic [2:0] bv, input int n);
    for (int i = 0; i < n; i++) step(av, bv);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 3'($urandom);
      b = 3'($urandom);
      @(posedge clk);
    end
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // reset held with random bus activity
    do_reset();
    reset = 1'b0;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_dwell", 32'(dwell), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_pulse", 32'(err_pulse), 0);
    chk("rst_cyc", 32'(cycles_done), 0);
    reset = 1'b1;

    // clean loops
    step(G, R);
    chk("loop_lock1", 32'(locked), 1);
    chk("loop_dwell1", 32'(dwell), 1);
    rep(G, R, 3);
    chk("loop_dwell4", 32'(dwell), 4);
    step(Y, R);
    chk("loop_ay", 32'(phase), 1);
    rep(R, G, 3);
    chk("loop_bg", 32'(phase), 2);
    chk("loop_bg_dw", 32'(dwell), 3);
    step(R, Y);
    chk("loop_by", 32'(phase), 3);
    step(G, R);
    chk("loop_cyc0", 32'(cycles_done), 0);
    rep(G, R, 3);
    step(Y, R);
    rep(R, G, 3);
    step(R, Y);
    chk("loop_cyc_by", 32'(cycles_done), 0);
    step(G, R);
    chk("loop_cyc1", 32'(cycles_done), 1);
    chk("loop_err", 32'(err), 0);
    chk("loop_ph_ag", 32'(phase), 0);

    // illegal encoding in TRACK, then relock
    step(3'b110, R);
    chk("enc_pulse", 32'(err_pulse), 1);
    chk("enc_err", 32'(err), 1);
    chk("enc_code", 32'(err_code), 1);
    chk("enc_locked", 32'(locked), 0);
    chk("enc_dwell", 32'(dwell), 0);
    step(G, R);
    chk("enc_relock", 32'(locked), 1);
    chk("enc_re_dw", 32'(dwell), 1);
    chk("enc_pulse0", 32'(err_pulse), 0);
    chk("enc_code_k", 32'(err_code), 1);

    // skip AG -> BG
    do_reset();
    step(G, R);
    step(R, G);
    chk("skip_code", 32'(err_code), 2);
    chk("skip_phase", 32'(phase), 2);
    chk("skip_pulse", 32'(err_pulse), 1);
    chk("skip_lock", 32'(locked), 1);
    step(R, Y);
    step(G, R);
    chk("skip_cyc", 32'(cycles_done), 0);
    chk("skip_pulse0", 32'(err_pulse), 0);

    // short timed BG
    do_reset();
    step(G, R);
    step(Y, R);
    rep(R, G, 2);
    chk("short_pre", 32'(err), 0);
    step(R, Y);
    chk("short_err", 32'(err), 32'(TC));
    chk("short_code", 32'(err_code), TC ? 3 : 0);
    chk("short_pulse", 32'(err_pulse), 32'(TC));

    // long timed AG
    do_reset();
    step(R, Y);
    rep(G, R, 4);
    chk("long_pre", 32'(err), 0);
    chk("long_dw4", 32'(dwell), 4);
    step(G, R);
    chk("long_err", 32'(err), 32'(TC));
    chk("long_code", 32'(err_code), TC ? 4 : 0);
    chk("long_pulse", 32'(err_pulse), 32'(TC));
    step(G, R);
    chk("long_once", 32'(err_pulse), 0);
    chk("long_dw6", 32'(dwell), 6);

    // asynchronous reset mid-phase
    do_reset();
    step(G, R);
    step(Y, R);
    rep(R, G, 2);
    chk("mid_dw2", 32'(dwell), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_phase", 32'(phase), 0);
    chk("mid_locked", 32'(locked), 0);
    chk("mid_dwell", 32'(dwell), 0);
    #1;
    reset = 1'b1;
    step(R, G);
    chk("mid_relock", 32'(locked), 1);
    chk("mid_re_dw", 32'(dwell), 1);
    chk("mid_re_ph", 32'(phase), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

- Passive observer on the two-way signal-head bus driven by the intersection controller.
- Samples the one-hot light vectors of both approaches and decodes the current phase.
- Checks encoding, phase order and per-phase dwell time, and reports status and errors to the supervisor/debug logic.
- Never drives the lights.

## Interface
- T_AG, default 4: required A-green/B-red dwell, in cycles.
- T_AY, default 1: required A-yellow/B-red dwell.
- T_BG, default 3: required A-red/B-green dwell.
- T_BY, default 1: required A-red/B-yellow dwell.
- CNT_W, default 16: width of the completed-cycle counter.
- clk  input  1  clock; all sampling on posedge.
- reset  input  1  asynchronous, active-low reset.
- A  input  3  approach A lights, one-hot: 100 red, 010 yellow, 001 green.
- B  input  3  approach B lights, same encoding.
- phase  output  2  decoded phase: 0 AG, 1 AY, 2 BG, 3 BY.
- locked  output  1  monitor is synchronised to a legal phase.
- dwell  output  8  cycles spent in the current phase, saturating at 255.
- err  output  1  sticky error flag.
- err_code  output  3  code of the first error since reset.
- err_pulse  output  1  one-cycle strobe per detected violation.
- cycles_done  output  CNT_W  number of completed AG→AY→BG→BY→AG loops; wraps modulo 2^CNT_W.

## Operation
- Legal {A,B} pairs:
  - {001,100} → AG
  - {010,100} → AY
  - {100,001} → BG
  - {100,010} → BY
  - Any other pair is illegal, including all-dark and both-red.
- State machine: SYNC → TRACK.
  - SYNC: on a legal sample → TRACK; set phase, dwell=1, mark the phase untimed (partial first phase).
  - TRACK, same phase: dwell+1, saturating.
  - TRACK, successor phase (AG→AY→BG→BY→AG): new phase, dwell=1, phase timed.
  - BY→AG transition increments cycles_done, but only if the whole loop was observed since the last sync.
  - TRACK, legal non-successor phase (skip or reverse): err_code 2; resync to the new phase as untimed; dwell=1; the loop is marked incomplete.
  - Any state, illegal pair: err_code 1; → SYNC; locked=0; dwell=0.
- Timing check, applied to timed phases only:
  - Exit with dwell < T_x: err_code 3 (short).
  - Sample in which dwell would reach T_x+1 while still in the phase: err_code 4 (long). Flagged once per phase occurrence.
- Error reporting:
  - err_code latches only the first error; err is sticky until reset.
  - err_pulse fires for every violation, including later ones.
- Simultaneous events: an illegal encoding takes priority over timing and order checks in the same sample.
- Reset values: phase=0, locked=0, dwell=0, err=0, err_code=0, err_pulse=0, cycles_done=0; state SYNC.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). The first sample after release is treated as fresh from SYNC.

## Timing
- A and B are sampled on every posedge; all outputs are registered.
- Latency: the effect of the sample at edge n is visible after edge n.
- err_pulse is high for exactly one cycle, aligned with the err_code/err update.
- dwell counts sampled cycles. A phase held for N edges shows dwell=N on its last cycle.
- Long error on phase X is flagged at the (T_x+1)-th sample of X.
- cycles_done updates in the same cycle that phase becomes AG.

## Configuration
- TLM_TIMING_CHECK_EN defined: dwell-time checks (codes 3 and 4) are active.
- TLM_TIMING_CHECK_EN undefined:
  - No duration checking; codes 3 and 4 are never produced.
  - dwell still counts.
  - Encoding and order checks are unchanged.

## Test plan
- Reset: hold reset=0, toggle A/B arbitrarily → all outputs 0.
- Clean loops, macro on: release reset, drive AG×4, AY×1, BG×3, BY×1, AG×4, AY×1, BG×3, BY×1, AG →
  - locked=1 after the first edge;
  - err stays 0;
  - cycles_done=1 on entering the third AG (the first loop is partial-start).
- Illegal encoding: in TRACK, drive {110,100} for 1 cycle →
  - err_pulse 1 cycle, err=1, err_code=1, locked=0;
  - the next legal sample relocks.
- Skip: AG→BG directly → err_code=2; phase=2; no cycles_done increment on the next AG.
- Dwell errors, macro on:
  - timed BG held 2 then BY → err_code=3;
  - fresh run after reset, timed AG held 5 → err_code=4 on the 5th AG sample, err_pulse once only.
  - Macro off: both cases give err=0.
- Reset mid-phase: assert reset during BG dwell=2 → outputs clear at once; after release, the first legal sample gives locked=1, dwell=1.
